// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sa_pkg
//  Brief    : Shared systolic-array constants, feeder state type and the
//             instruction-word packing helper used by feeder and array decoder.
//  Revision : 1.0  initial release
// ============================================================================
package sa_pkg;

    localparam int SA_DATA_WIDTH = 256;
    localparam int SA_LANES      = 32;
    localparam int SA_CNT_W      = 5;
    localparam int SA_DEPTH      = 32;
    localparam int SA_ADDR_W     = $clog2(SA_DEPTH);
    localparam int SA_CMD_W      = 2 * SA_CNT_W;
    localparam int SA_INSTR_W    = 32;

    // Instruction word field offsets, also decoded by the array top
    localparam int NCOLS_LSB = 0;
    localparam int NROWS_LSB = 5;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_INSTR  = 2'd1,
        FEED_PRIME  = 2'd2,
        FEED_STREAM = 2'd3
    } feed_state_t;

    function automatic logic [SA_INSTR_W-1:0] sa_pack_instr(
        input logic [SA_CNT_W-1:0] n_rows,
        input logic [SA_CNT_W-1:0] n_cols
    );
        logic [SA_INSTR_W-1:0] v;
        v = '0;
        v[NROWS_LSB +: SA_CNT_W] = n_rows;
        v[NCOLS_LSB +: SA_CNT_W] = n_cols;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_stream_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : sa_stream_feeder_if
//  Brief    : Host load/command channels and the three array-facing streams.
//  Revision : 1.0  initial release
// ============================================================================
interface sa_stream_feeder_if;
    import sa_pkg::*;

    logic                     load_valid;
    logic                     load_ready;
    logic                     load_sel;
    logic [SA_ADDR_W-1:0]     load_addr;
    logic [SA_DATA_WIDTH-1:0] load_data;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [SA_CMD_W-1:0]      cmd_data;

    logic [SA_INSTR_W-1:0]    st_instr_data;
    logic                     st_instr_valid;
    logic                     st_instr_ready;

    logic [SA_DATA_WIDTH-1:0] st_rows_data;
    logic                     st_rows_valid;
    logic                     st_rows_ready;

    logic [SA_DATA_WIDTH-1:0] st_cols_data;
    logic                     st_cols_valid;
    logic                     st_cols_ready;

    logic                     busy;
    logic                     done;
    logic                     cmd_err;

    modport master (
        output load_valid, load_sel, load_addr, load_data,
        output cmd_valid, cmd_data,
        output st_instr_ready, st_rows_ready, st_cols_ready,
        input  load_ready, cmd_ready,
        input  st_instr_data, st_instr_valid,
        input  st_rows_data, st_rows_valid,
        input  st_cols_data, st_cols_valid,
        input  busy, done, cmd_err
    );

    modport slave (
        input  load_valid, load_sel, load_addr, load_data,
        input  cmd_valid, cmd_data,
        input  st_instr_ready, st_rows_ready, st_cols_ready,
        output load_ready, cmd_ready,
        output st_instr_data, st_instr_valid,
        output st_rows_data, st_rows_valid,
        output st_cols_data, st_cols_valid,
        output busy, done, cmd_err
    );

endinterface
`default_nettype wire

// File: rtl/sa_feed_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : sa_feed_buffer
//  Brief    : Simple dual-port operand RAM, one write port and one registered
//             read port with read enable (output holds when not reading).
//  Revision : 1.0  initial release
// ============================================================================
module sa_feed_buffer
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int DEPTH      = SA_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  i_wr_en,
    input  wire logic [ADDR_W-1:0]     i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wr_data,
    input  wire logic                  i_rd_en,
    input  wire logic [ADDR_W-1:0]     i_rd_addr,
    output logic      [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sa_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : sa_stream_feeder
//  Brief    : Buffers row/col operand tiles, then streams one instruction word
//             followed by min(n_rows,n_cols) lockstep row/col beats.
//  Revision : 1.0  initial release
// ============================================================================
module sa_stream_feeder
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int DEPTH      = SA_DEPTH,
    parameter int CNT_W      = SA_CNT_W
) (
    input  wire logic         clock_sink,
    input  wire logic         reset_sink_reset_n,
    sa_stream_feeder_if.slave bus
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    feed_state_t r_state;
    feed_state_t w_state_next;

    logic                  r_instr_valid;
    logic [SA_INSTR_W-1:0] r_instr_data;
    logic                  r_st_valid;
    logic [DATA_WIDTH-1:0] r_rows_data;
    logic [DATA_WIDTH-1:0] r_cols_data;
    logic [CNT_W-1:0]      r_beat;
    logic [CNT_W-1:0]      r_last;
    logic                  r_done;
    logic                  r_cmd_err;

    logic [CNT_W-1:0]      w_cmd_rows;
    logic [CNT_W-1:0]      w_cmd_cols;
    logic [CNT_W-1:0]      w_cmd_min;
    logic                  w_idle;
    logic                  w_cmd_bad;
    logic                  w_cmd_go;
    logic                  w_instr_hs;
    logic                  w_beat_acc;
    logic                  w_last_acc;
    logic                  w_rd_en;
    logic [c_ADDR_W-1:0]   w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rows_rd;
    logic [DATA_WIDTH-1:0] w_cols_rd;

    assign w_cmd_rows = bus.cmd_data[NROWS_LSB +: CNT_W];
    assign w_cmd_cols = bus.cmd_data[NCOLS_LSB +: CNT_W];
    assign w_cmd_min  = (w_cmd_rows < w_cmd_cols) ? w_cmd_rows : w_cmd_cols;
    assign w_idle     = (r_state == FEED_IDLE);
    assign w_cmd_bad  = w_idle && bus.cmd_valid && ((w_cmd_rows == '0) || (w_cmd_cols == '0));
    assign w_cmd_go   = w_idle && bus.cmd_valid && !w_cmd_bad;
    assign w_instr_hs = (r_state == FEED_INSTR) && bus.st_instr_ready;
    assign w_beat_acc = (r_state == FEED_STREAM) && bus.st_rows_ready && bus.st_cols_ready;
    assign w_last_acc = w_beat_acc && (r_beat == r_last);

    sa_feed_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(c_ADDR_W)) u_rows_buf (
        .clk       (clock_sink),
        .i_wr_en   (w_idle && bus.load_valid && !bus.load_sel),
        .i_wr_addr (bus.load_addr),
        .i_wr_data (bus.load_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rows_rd)
    );

    sa_feed_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(c_ADDR_W)) u_cols_buf (
        .clk       (clock_sink),
        .i_wr_en   (w_idle && bus.load_valid && bus.load_sel),
        .i_wr_addr (bus.load_addr),
        .i_wr_data (bus.load_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_cols_rd)
    );

    // The RAM runs one entry ahead of the output registers: while beat k is
    // presented, entry k+1 already sits on the read port, so an accept can
    // load it immediately and fetch k+2 in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        case (r_state)
            FEED_IDLE: begin
                if (w_cmd_go) begin
                    w_state_next = FEED_INSTR;
                end
            end
            FEED_INSTR: begin
                if (w_instr_hs) begin
                    w_state_next = FEED_PRIME;
                    w_rd_en      = 1'b1;
                end
            end
            FEED_PRIME: begin
                w_state_next = FEED_STREAM;
                w_rd_en      = 1'b1;
                w_rd_addr    = c_ADDR_W'(1);
            end
            FEED_STREAM: begin
                if (w_beat_acc) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = c_ADDR_W'(r_beat) + c_ADDR_W'(2);
                    if (w_last_acc) begin
                        w_state_next = FEED_IDLE;
                    end
                end
            end
            default: w_state_next = FEED_IDLE;
        endcase
    end

    always_ff @(posedge clock_sink) begin
        if (!reset_sink_reset_n) begin
            r_state       <= FEED_IDLE;
            r_instr_valid <= 1'b0;
            r_instr_data  <= '0;
            r_st_valid    <= 1'b0;
            r_rows_data   <= '0;
            r_cols_data   <= '0;
            r_beat        <= '0;
            r_last        <= '0;
            r_done        <= 1'b0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_done    <= w_last_acc;
            r_cmd_err <= w_cmd_bad;

            if (w_cmd_go) begin
                r_instr_valid <= 1'b1;
                r_instr_data  <= sa_pack_instr(w_cmd_rows, w_cmd_cols);
                r_last        <= w_cmd_min - CNT_W'(1);
            end else if (w_instr_hs) begin
                r_instr_valid <= 1'b0;
            end

            if (r_state == FEED_PRIME) begin
                r_st_valid  <= 1'b1;
                r_rows_data <= w_rows_rd;
                r_cols_data <= w_cols_rd;
                r_beat      <= '0;
            end else if (w_last_acc) begin
                r_st_valid <= 1'b0;
                r_beat     <= '0;
            end else if (w_beat_acc) begin
                r_rows_data <= w_rows_rd;
                r_cols_data <= w_cols_rd;
                r_beat      <= r_beat + CNT_W'(1);
            end
        end
    end

    assign bus.load_ready     = w_idle;
    assign bus.cmd_ready      = w_idle;
    assign bus.busy           = !w_idle;
    assign bus.done           = r_done;
    assign bus.cmd_err        = r_cmd_err;
    assign bus.st_instr_valid = r_instr_valid;
    assign bus.st_instr_data  = r_instr_data;
    assign bus.st_rows_valid  = r_st_valid;
    assign bus.st_rows_data   = r_rows_data;
    assign bus.st_cols_valid  = r_st_valid;
    assign bus.st_cols_data   = r_cols_data;

endmodule
`default_nettype wire

// File: tb/tb_sa_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sa_stream_feeder
//  Brief    : Self-checking bench for sa_stream_feeder with a buffer/beat model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sa_stream_feeder;
    import sa_pkg::*;

    logic clock_sink = 1'b0;
    logic reset_sink_reset_n = 1'b0;
    always #5 clock_sink = ~clock_sink;

    sa_stream_feeder_if bus();

    sa_stream_feeder dut (
        .clock_sink         (clock_sink),
        .reset_sink_reset_n (reset_sink_reset_n),
        .bus                (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference copy of what the host has written into each operand buffer
    logic [255:0] rows_mem [32];
    logic [255:0] cols_mem [32];

    function automatic logic [255:0] rand_word();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] lane_fill(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {32{b}};
    endfunction

    task automatic load_entry(input logic sel, input int addr, input logic [255:0] d);
        @(negedge clock_sink);
        n_checks++;
        if (bus.load_ready !== 1'b1) $display("FAIL load_ready_idle got=%b exp=1", bus.load_ready);
        else n_pass++;
        bus.load_valid = 1'b1;
        bus.load_sel   = sel;
        bus.load_addr  = 5'(addr);
        bus.load_data  = d;
        @(negedge clock_sink);
        bus.load_valid = 1'b0;
        if (sel) cols_mem[addr] = d;
        else     rows_mem[addr] = d;
    endtask

    // mode 0: readies held high; 1: random readies plus stray loads; 2: cols_ready low on stream cycles 2..4
    task automatic stream_cmd(input int nr, input int nc, input int instr_delay, input int mode,
                              input bit co_load, input logic [255:0] co_data);
        int nb;
        int k;
        int cyc;
        logic [31:0] exp_instr;
        bit rr;
        bit cr;
        nb = (nr < nc) ? nr : nc;
        exp_instr = 32'((nr << 5) | nc);

        @(negedge clock_sink);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle got=%b exp=1", bus.cmd_ready);
        else n_pass++;
        bus.cmd_valid      = 1'b1;
        bus.cmd_data       = 10'((nr << 5) | nc);
        bus.st_instr_ready = (instr_delay == 0);
        bus.st_rows_ready  = (mode == 0);
        bus.st_cols_ready  = (mode == 0);
        if (co_load) begin
            bus.load_valid = 1'b1;
            bus.load_sel   = 1'b0;
            bus.load_addr  = '0;
            bus.load_data  = co_data;
        end
        @(negedge clock_sink);
        bus.cmd_valid  = 1'b0;
        bus.load_valid = 1'b0;
        if (co_load) rows_mem[0] = co_data;

        n_checks++;
        if (bus.st_instr_valid !== 1'b1 || bus.st_instr_data !== exp_instr)
            $display("FAIL instr_word valid=%b data=%h exp_valid=1 exp_data=%h", bus.st_instr_valid, bus.st_instr_data, exp_instr);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0)
            $display("FAIL busy_after_cmd busy=%b cmd_ready=%b exp busy=1 cmd_ready=0", bus.busy, bus.cmd_ready);
        else n_pass++;

        for (int d = 0; d < instr_delay; d++) begin
            @(negedge clock_sink);
            n_checks++;
            if (bus.st_instr_valid !== 1'b1 || bus.st_instr_data !== exp_instr)
                $display("FAIL instr_hold valid=%b data=%h exp_data=%h", bus.st_instr_valid, bus.st_instr_data, exp_instr);
            else n_pass++;
            if (d == instr_delay - 1) bus.st_instr_ready = 1'b1;
        end

        @(negedge clock_sink);
        bus.st_instr_ready = 1'b0;
        n_checks++;
        if (bus.st_instr_valid !== 1'b0 || bus.st_rows_valid !== 1'b0)
            $display("FAIL prime_cycle instr_valid=%b rows_valid=%b exp 0 0", bus.st_instr_valid, bus.st_rows_valid);
        else n_pass++;
        @(negedge clock_sink);

        k = 0;
        cyc = 1;
        while (k < nb && cyc <= 400) begin
            n_checks++;
            if (bus.st_rows_valid !== 1'b1 || bus.st_cols_valid !== 1'b1 || bus.done !== 1'b0)
                $display("FAIL beat_valid k=%0d rows_v=%b cols_v=%b done=%b exp 1 1 0", k, bus.st_rows_valid, bus.st_cols_valid, bus.done);
            else n_pass++;
            n_checks++;
            if (bus.st_rows_data !== rows_mem[k])
                $display("FAIL beat_rows k=%0d got=%h exp=%h", k, bus.st_rows_data, rows_mem[k]);
            else n_pass++;
            n_checks++;
            if (bus.st_cols_data !== cols_mem[k])
                $display("FAIL beat_cols k=%0d got=%h exp=%h", k, bus.st_cols_data, cols_mem[k]);
            else n_pass++;

            case (mode)
                0:       begin rr = 1'b1; cr = 1'b1; end
                1:       begin rr = ($urandom_range(0, 3) != 0); cr = ($urandom_range(0, 3) != 0); end
                default: begin rr = 1'b1; cr = !(cyc >= 2 && cyc <= 4); end
            endcase
            if (mode == 1) begin
                n_checks++;
                if (bus.load_ready !== 1'b0) $display("FAIL load_ready_busy got=%b exp=0", bus.load_ready);
                else n_pass++;
                bus.load_valid = 1'b1;
                bus.load_sel   = 1'($urandom_range(0, 1));
                bus.load_addr  = 5'($urandom_range(0, 31));
                bus.load_data  = rand_word();
            end
            bus.st_rows_ready = rr;
            bus.st_cols_ready = cr;
            @(negedge clock_sink);
            bus.load_valid = 1'b0;
            cyc++;
            if (rr && cr) k++;
        end

        n_checks++;
        if (k != nb) $display("FAIL stream_timeout beats=%0d exp=%0d", k, nb);
        else n_pass++;
        n_checks++;
        if (bus.st_rows_valid !== 1'b0 || bus.st_cols_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL stream_end rows_v=%b cols_v=%b done=%b busy=%b exp 0 0 1 0",
                     bus.st_rows_valid, bus.st_cols_valid, bus.done, bus.busy);
        else n_pass++;
        @(negedge clock_sink);
        n_checks++;
        if (bus.done !== 1'b0 || bus.st_rows_valid !== 1'b0)
            $display("FAIL done_pulse done=%b rows_v=%b exp 0 0", bus.done, bus.st_rows_valid);
        else n_pass++;
        bus.st_rows_ready = 1'b0;
        bus.st_cols_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_sink_reset_n = 1'b0;
        repeat (3) @(negedge clock_sink);
        n_checks++;
        if (bus.st_instr_valid !== 1'b0 || bus.st_rows_valid !== 1'b0 || bus.st_cols_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_err !== 1'b0)
            $display("FAIL reset_ctrl iv=%b rv=%b cv=%b busy=%b done=%b err=%b exp all 0", bus.st_instr_valid,
                     bus.st_rows_valid, bus.st_cols_valid, bus.busy, bus.done, bus.cmd_err);
        else n_pass++;
        n_checks++;
        if (bus.st_instr_data !== 32'h0 || bus.st_rows_data !== 256'h0 || bus.st_cols_data !== 256'h0)
            $display("FAIL reset_data instr=%h rows=%h cols=%h exp 0", bus.st_instr_data, bus.st_rows_data, bus.st_cols_data);
        else n_pass++;
        reset_sink_reset_n = 1'b1;
        @(negedge clock_sink);
        n_checks++;
        if (bus.load_ready !== 1'b1 || bus.cmd_ready !== 1'b1)
            $display("FAIL idle_ready load_ready=%b cmd_ready=%b exp 1 1", bus.load_ready, bus.cmd_ready);
        else n_pass++;
    endtask

    task automatic test_square4();
        for (int i = 0; i < 4; i++) begin
            load_entry(1'b0, i, lane_fill(i));
            load_entry(1'b1, i, lane_fill(i));
        end
        stream_cmd(4, 4, 0, 0, 1'b0, '0);
    endtask

    task automatic test_uneven();
        for (int i = 0; i < 7; i++) begin
            load_entry(1'b0, i, rand_word());
            load_entry(1'b1, i, rand_word());
        end
        // Load and command in the same cycle: the stream must see the new row 0
        stream_cmd(7, 3, 0, 0, 1'b1, rand_word());
    endtask

    task automatic test_cols_stall();
        for (int i = 0; i < 5; i++) begin
            load_entry(1'b0, i, rand_word());
            load_entry(1'b1, i, rand_word());
        end
        stream_cmd(5, 5, 0, 2, 1'b0, '0);
    endtask

    task automatic test_cmd_err();
        logic [9:0] bad [2];
        bad[0] = 10'h020;
        bad[1] = 10'h0A0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_sink);
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = bad[i];
            @(negedge clock_sink);
            bus.cmd_valid = 1'b0;
            n_checks++;
            if (bus.cmd_err !== 1'b1 || bus.st_instr_valid !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL cmd_err_pulse err=%b iv=%b busy=%b exp 1 0 0", bus.cmd_err, bus.st_instr_valid, bus.busy);
            else n_pass++;
            @(negedge clock_sink);
            n_checks++;
            if (bus.cmd_err !== 1'b0 || bus.st_instr_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
                $display("FAIL cmd_err_after err=%b iv=%b cmd_ready=%b exp 0 0 1", bus.cmd_err, bus.st_instr_valid, bus.cmd_ready);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        int waits;
        for (int i = 0; i < 8; i++) begin
            load_entry(1'b0, i, rand_word());
            load_entry(1'b1, i, rand_word());
        end
        @(negedge clock_sink);
        bus.cmd_valid      = 1'b1;
        bus.cmd_data       = 10'((8 << 5) | 8);
        bus.st_instr_ready = 1'b1;
        bus.st_rows_ready  = 1'b1;
        bus.st_cols_ready  = 1'b1;
        @(negedge clock_sink);
        bus.cmd_valid = 1'b0;
        waits = 0;
        while (bus.st_rows_valid !== 1'b1 && waits < 20) begin
            @(negedge clock_sink);
            waits++;
        end
        repeat (2) @(negedge clock_sink);
        n_checks++;
        if (bus.st_rows_data !== rows_mem[2])
            $display("FAIL abort_beat2 got=%h exp=%h", bus.st_rows_data, rows_mem[2]);
        else n_pass++;
        reset_sink_reset_n = 1'b0;
        @(negedge clock_sink);
        n_checks++;
        if (bus.st_rows_valid !== 1'b0 || bus.st_cols_valid !== 1'b0 || bus.st_instr_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.st_rows_data !== 256'h0)
            $display("FAIL abort_state rv=%b cv=%b iv=%b busy=%b done=%b rows=%h exp all 0", bus.st_rows_valid,
                     bus.st_cols_valid, bus.st_instr_valid, bus.busy, bus.done, bus.st_rows_data);
        else n_pass++;
        reset_sink_reset_n = 1'b1;
        bus.st_instr_ready = 1'b0;
        @(negedge clock_sink);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL abort_no_done done=%b busy=%b exp 0 0", bus.done, bus.busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            load_entry(1'b0, i, rand_word());
            load_entry(1'b1, i, rand_word());
        end
        stream_cmd(3, 3, 0, 0, 1'b0, '0);
    endtask

    task automatic test_full_random();
        for (int i = 0; i < 31; i++) begin
            load_entry(1'b0, i, rand_word());
            load_entry(1'b1, i, rand_word());
        end
        stream_cmd(31, 31, 3, 1, 1'b0, '0);
    endtask

    initial begin
        bus.load_valid     = 1'b0;
        bus.load_sel       = 1'b0;
        bus.load_addr      = '0;
        bus.load_data      = '0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_data       = '0;
        bus.st_instr_ready = 1'b0;
        bus.st_rows_ready  = 1'b0;
        bus.st_cols_ready  = 1'b0;

        test_reset();
        test_square4();
        test_uneven();
        test_cols_stall();
        test_cmd_err();
        test_reset_abort();
        test_full_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
